// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA sync/blank timing with pixel request, aligned colour output.
//            Optional colour-bar generator built when VGA_TEST_PATTERN_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACT      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACT      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2,
    parameter int COLOR_W    = 8,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic               iTest_mode,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oReq,
    output logic [9:0]         oCoord_X,
    output logic [9:0]         oCoord_Y,
    output logic               oFrame_start,
    output logic               oLine_end,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC
);

    localparam int c_H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int c_V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int c_HW    = $clog2(c_H_TOT + 1);
    localparam int c_VW    = $clog2(c_V_TOT + 1);

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOT - 1);
    localparam logic [c_HW-1:0] c_H_SYNC_END = c_HW'(H_SYNC);
    localparam logic [c_HW-1:0] c_H_ACT_BEG  = c_HW'(H_SYNC + H_BP);
    localparam logic [c_HW-1:0] c_H_ACT_END  = c_HW'(H_SYNC + H_BP + H_ACT);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOT - 1);
    localparam logic [c_VW-1:0] c_V_SYNC_END = c_VW'(V_SYNC);
    localparam logic [c_VW-1:0] c_V_ACT_BEG  = c_VW'(V_SYNC + V_BP);
    localparam logic [c_VW-1:0] c_V_ACT_END  = c_VW'(V_SYNC + V_BP + V_ACT);
    localparam logic [9:0]      c_X_LAST     = 10'(H_ACT - 1);

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_PW    = 13;
    localparam int c_BAR_W = H_ACT / 8;
`else
    localparam int c_PW    = 3;
`endif

    logic [c_HW-1:0]    r_h_cnt;
    logic [c_VW-1:0]    r_v_cnt;
    logic               w_h_act;
    logic               w_v_act;
    logic               w_hs;
    logic               w_vs;
    logic [c_PW-1:0]    w_raw;
    logic [c_PW-1:0]    w_dly;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (Enable) begin
            if (r_h_cnt == c_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + c_HW'(1);
            end
        end
    end

    assign w_h_act      = (r_h_cnt >= c_H_ACT_BEG) && (r_h_cnt < c_H_ACT_END);
    assign w_v_act      = (r_v_cnt >= c_V_ACT_BEG) && (r_v_cnt < c_V_ACT_END);
    assign w_hs         = (r_h_cnt < c_H_SYNC_END);
    assign w_vs         = (r_v_cnt < c_V_SYNC_END);
    assign oReq         = w_h_act && w_v_act;
    assign oCoord_X     = 10'(r_h_cnt - c_H_ACT_BEG);
    assign oCoord_Y     = 10'(r_v_cnt - c_V_ACT_BEG);
    assign oFrame_start = Enable && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign oLine_end    = Enable && oReq && (oCoord_X == c_X_LAST);
    assign oVGA_SYNC    = 1'b0;

    // Delay line payload: {[x,] hsync, vsync, active}; x only rides along for the bar generator
`ifdef VGA_TEST_PATTERN_EN
    assign w_raw = {oCoord_X, w_hs, w_vs, oReq};
`else
    assign w_raw = {w_hs, w_vs, oReq};
`endif

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign w_dly = w_raw;
        end else begin : g_delay
            logic [c_PW-1:0] r_pipe [PIPE_DELAY];
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= '0;
                end else if (Enable) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_dly = r_pipe[PIPE_DELAY-1];
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;
    // Bar index bits map directly to channels: R=~b1, G=~b2, B=~b0 gives W,Y,C,G,M,R,B,K
    assign w_bar = 3'(w_dly[c_PW-1 -: 10] / 10'(c_BAR_W));
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = iTest_mode;
`endif

    always_comb begin
        w_r = iRed;
        w_g = iGreen;
        w_b = iBlue;
`ifdef VGA_TEST_PATTERN_EN
        if (iTest_mode) begin
            w_r = {COLOR_W{~w_bar[1]}};
            w_g = {COLOR_W{~w_bar[2]}};
            w_b = {COLOR_W{~w_bar[0]}};
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oVGA_R      <= '0;
            oVGA_G      <= '0;
            oVGA_B      <= '0;
            oVGA_BLANK  <= 1'b0;
            oVGA_H_SYNC <= ~HSYNC_POL;
            oVGA_V_SYNC <= ~VSYNC_POL;
        end else if (Enable) begin
            oVGA_H_SYNC <= w_dly[2] ? HSYNC_POL : ~HSYNC_POL;
            oVGA_V_SYNC <= w_dly[1] ? VSYNC_POL : ~VSYNC_POL;
            oVGA_BLANK  <= w_dly[0];
            oVGA_R      <= w_dly[0] ? w_r : '0;
            oVGA_G      <= w_dly[0] ? w_g : '0;
            oVGA_B      <= w_dly[0] ? w_b : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed bench: 640x480 instance for line-level timing, plus a
//            miniature-timing instance for whole-frame and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic       Clock = 1'b0;
    always #5 Clock = ~Clock;

    // full-size instance
    logic       rst, en, tmode;
    logic [7:0] red, grn, blu;
    logic       req, fs, le, hs, vs, blank, sync;
    logic [9:0] cx, cy;
    logic [7:0] vr, vg, vb;

    // miniature instance: H 4+3+16+2 = 25, V 2+2+6+1 = 11, frame = 275 cycles
    logic       s_rst, s_en;
    logic [7:0] s_red, s_grn, s_blu;
    logic       s_req, s_fs, s_le, s_hs, s_vs, s_blank, s_sync;
    logic [9:0] s_cx, s_cy;
    logic [7:0] s_r, s_g, s_b;

    int n_vec = 0;
    int n_err = 0;
    int bh = 0;
    int bv = 0;

    vga_timing_gen u_dut (
        .Clock(Clock), .Reset(rst), .Enable(en), .iTest_mode(tmode),
        .iRed(red), .iGreen(grn), .iBlue(blu),
        .oReq(req), .oCoord_X(cx), .oCoord_Y(cy),
        .oFrame_start(fs), .oLine_end(le),
        .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb),
        .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_BLANK(blank), .oVGA_SYNC(sync)
    );

    vga_timing_gen #(
        .H_ACT(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .Clock(Clock), .Reset(s_rst), .Enable(s_en), .iTest_mode(1'b0),
        .iRed(s_red), .iGreen(s_grn), .iBlue(s_blu),
        .oReq(s_req), .oCoord_X(s_cx), .oCoord_Y(s_cy),
        .oFrame_start(s_fs), .oLine_end(s_le),
        .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
        .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs), .oVGA_BLANK(s_blank), .oVGA_SYNC(s_sync)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one clock; bh/bv follow where the full-size counters should be
    task automatic tick();
        if (en && !rst) begin
            if (bh == 799) begin
                bh = 0;
                bv = (bv == 524) ? 0 : bv + 1;
            end else begin
                bh++;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic goto_pos(input int h, input int v);
        int guard = 0;
        while (!(bh == h && bv == v) && guard < 450000) begin
            tick();
            guard++;
        end
        if (guard >= 450000) begin
            n_vec++;
            n_err++;
            $error("FAIL goto_timeout observed=%0d/%0d expected=%0d/%0d", bh, bv, h, v);
        end
    endtask

    initial begin
        int n, c_hs, c_vs, c_fs, hh, hout;
        logic e_blank;

        rst = 1'b1; en = 1'b0; tmode = 1'b0;
        red = 8'h11; grn = 8'h22; blu = 8'h33;
        s_rst = 1'b1; s_en = 1'b0;
        s_red = 8'h11; s_grn = 8'h22; s_blu = 8'h33;
        repeat (3) tick();

        // ---------------- miniature instance: frame, syncs, mid-frame reset
        chk("s_rst_r", s_r, 8'h00);
        chk("s_rst_blank", s_blank, 1'b0);
        chk("s_rst_hs", s_hs, 1'b1);
        chk("s_rst_vs", s_vs, 1'b1);
        s_rst = 1'b0; s_en = 1'b1; #1;
        chk("s_first_fs", s_fs, 1'b1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_fs && n < 400);
        chk("s_frame_period", n, 275);
        c_hs = 0; c_vs = 0; c_fs = 0;
        for (int i = 0; i < 275; i++) begin
            if (!s_hs) c_hs++;
            if (!s_vs) c_vs++;
            if (s_fs) c_fs++;
            tick();
        end
        chk("s_hs_low_per_frame", c_hs, 44);
        chk("s_vs_low_per_frame", c_vs, 50);
        chk("s_fs_per_frame", c_fs, 1);
        chk("s_fs_again", s_fs, 1'b1);
        repeat (137) tick();                      // v=5, h=12: mid active area
        chk("s_mid_blank", s_blank, 1'b1);
        chk("s_mid_r", s_r, 8'h11);
        s_rst = 1'b1; s_en = 1'b0;
        tick();
        chk("s_mrst_r", s_r, 8'h00);
        chk("s_mrst_g", s_g, 8'h00);
        chk("s_mrst_blank", s_blank, 1'b0);
        chk("s_mrst_hs", s_hs, 1'b1);
        chk("s_mrst_vs", s_vs, 1'b1);
        chk("s_mrst_req", s_req, 1'b0);
        s_rst = 1'b0; s_en = 1'b1; #1;
        chk("s_release_fs", s_fs, 1'b1);
        tick();
        chk("s_fs_strobe_end", s_fs, 1'b0);
        chk("s_sync_tied", s_sync, 1'b0);

        // ---------------- full-size instance
        chk("rst_r", vr, 8'h00);
        chk("rst_blank", blank, 1'b0);
        chk("rst_hs", hs, 1'b1);
        chk("rst_vs", vs, 1'b1);
        chk("rst_fs_disabled", fs, 1'b0);
        rst = 1'b0; en = 1'b1; bh = 0; bv = 0; #1;
        chk("release_fs", fs, 1'b1);
        chk("release_req", req, 1'b0);

        goto_pos(0, 1);
        c_hs = 0;
        for (int i = 0; i < 800; i++) begin
            if (!hs) c_hs++;
            tick();
        end
        chk("hs_low_per_line", c_hs, 96);
        goto_pos(2, 2);
        chk("hs_before_edge", hs, 1'b1);
        chk("vs_tail", vs, 1'b0);
        tick();
        chk("hs_first_low", hs, 1'b0);
        chk("vs_release", vs, 1'b1);
        goto_pos(98, 2);
        chk("hs_last_low", hs, 1'b0);
        tick();
        chk("hs_after_pulse", hs, 1'b1);

        // first active line: request window, colour latency, blanking edges
        goto_pos(143, 35);
        for (int k = 0; k < 645; k++) begin
            case (bh)
                143: chk("req_before", req, 1'b0);
                144: begin
                    chk("req_first", req, 1'b1);
                    chk("x_first", cx, 10'd0);
                    chk("y_first", cy, 10'd0);
                end
                146: begin
                    chk("blank_lead", blank, 1'b0);
                    chk("r_lead", vr, 8'h00);
                end
                147: begin
                    chk("blank_first", blank, 1'b1);
                    chk("r_first", vr, 8'h11);
                end
                156: begin
                    chk("r_pre_pulse", vr, 8'h11);
                    red = 8'hA5;
                end
                157: begin
                    chk("r_pulse", vr, 8'hA5);
                    chk("blank_pulse", blank, 1'b1);
                    chk("hs_pulse", hs, 1'b1);
                    chk("vs_pulse", vs, 1'b1);
                    red = 8'h11;
                end
                158: chk("r_post_pulse", vr, 8'h11);
                782: chk("le_early", le, 1'b0);
                783: begin
                    chk("x_last", cx, 10'd639);
                    chk("le_last", le, 1'b1);
                    chk("req_last", req, 1'b1);
                end
                784: chk("req_after", req, 1'b0);
                786: chk("blank_last", blank, 1'b1);
                787: begin
                    chk("blank_trail", blank, 1'b0);
                    chk("r_trail", vr, 8'h00);
                end
                default: ;
            endcase
            tick();
        end

        // Enable alternating 0/1 across the end of line 36
        goto_pos(780, 36);
        for (int i = 0; i < 16; i++) begin
            en  = i[0];
            red = en ? 8'h11 : 8'h5A;
            #1;
            hh      = 780 + i / 2;
            hout    = 777 + i / 2;
            e_blank = (hout <= 783);
            chk("en_req", req, (hh <= 783) ? 1'b1 : 1'b0);
            chk("en_le", le, (i[0] && hh == 783) ? 1'b1 : 1'b0);
            chk("en_fs", fs, 1'b0);
            chk("en_blank", blank, e_blank);
            chk("en_r", vr, e_blank ? 8'h11 : 8'h00);
            tick();
        end
        en = 1'b1; red = 8'h11;

        // test-mode line
        goto_pos(140, 37);
        tmode = 1'b1;
        goto_pos(147, 37);
`ifdef VGA_TEST_PATTERN_EN
        chk("pat_x0", {vr, vg, vb}, 24'hFFFFFF);
        goto_pos(226, 37);
        chk("pat_x79", {vr, vg, vb}, 24'hFFFFFF);
        tick();
        chk("pat_x80", {vr, vg, vb}, 24'hFFFF00);
        goto_pos(707, 37);
        chk("pat_x560", {vr, vg, vb}, 24'h000000);
        chk("pat_x560_blank", blank, 1'b1);
        goto_pos(786, 37);
        chk("pat_x639", {vr, vg, vb}, 24'h000000);
`else
        chk("nopat_x0", {vr, vg, vb}, 24'h112233);
        goto_pos(707, 37);
        chk("nopat_x560", {vr, vg, vb}, 24'h112233);
`endif
        tmode = 1'b0;
        chk("sync_tied", sync, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACT, 480, active lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 2, cycles from oReq to iRed/iGreen/iBlue valid (0..15)
- COLOR_W, 8, bits per colour channel
- HSYNC_POL, 0, active level of oVGA_H_SYNC
- VSYNC_POL, 0, active level of oVGA_V_SYNC

REQ-002 SHALL have ports (name, direction, width, meaning):
- Clock, in, 1, single clock
- Reset, in, 1, synchronous active-high reset
- Enable, in, 1, pixel-clock enable; all state advances only when high
- iTest_mode, in, 1, select built-in pattern
- iRed/iGreen/iBlue, in, COLOR_W, pixel colour from the upstream fetch
- oReq, out, 1, pixel request
- oCoord_X/oCoord_Y, out, 10, coordinates of the requested pixel
- oFrame_start, out, 1, one-enabled-cycle strobe at the start of each frame
- oLine_end, out, 1, strobe on the last request of an active line
- oVGA_R/oVGA_G/oVGA_B, out, COLOR_W, registered colour
- oVGA_H_SYNC/oVGA_V_SYNC, out, 1, sync outputs
- oVGA_BLANK, out, 1, low during blanking
- oVGA_SYNC, out, 1, tied 0

Function
REQ-003 Totals SHALL be H_TOT = H_SYNC+H_BP+H_ACT+H_FP and V_TOT = V_SYNC+V_BP+V_ACT+V_FP; the counters SHALL be h_cnt in 0..H_TOT-1 and v_cnt in 0..V_TOT-1.
REQ-004 On each Enable cycle, h_cnt SHALL increment; at H_TOT-1 it SHALL wrap to 0 and v_cnt SHALL advance; v_cnt SHALL wrap to 0 after V_TOT-1.
REQ-005 Region order per line and per frame SHALL be sync, back porch, active, front porch, with count 0 being the first sync cycle.
REQ-006 oReq SHALL be high iff h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT); oReq is combinational from the counters.
REQ-007 oCoord_X SHALL equal h_cnt-(H_SYNC+H_BP) and oCoord_Y SHALL equal v_cnt-(V_SYNC+V_BP), truncated to 10 bits; both SHALL be valid only while oReq is high.
REQ-008 oFrame_start SHALL be high when h_cnt=0, v_cnt=0 and Enable=1; oLine_end SHALL be high when oReq=1, oCoord_X=H_ACT-1 and Enable=1.
REQ-009 Raw sync/active flags SHALL pass through a PIPE_DELAY-stage enabled delay line, then one output register, so that sync, blank and RGB are mutually aligned.
REQ-010 Sync outputs SHALL drive the HSYNC_POL/VSYNC_POL level during the sync regions and the opposite level otherwise.
REQ-011 The colour inputs SHALL be sampled PIPE_DELAY enabled cycles after the matching oReq; oVGA_R/G/B SHALL take the sampled colour one enabled cycle later, giving total latency PIPE_DELAY+1.
REQ-012 The delayed active flag SHALL gate the colour: oVGA_R/G/B SHALL be 0 wherever oVGA_BLANK=0.
REQ-013 With Enable=0, the counters, delay line and all registered outputs SHALL hold; the strobes SHALL be 0.
REQ-014 With PIPE_DELAY=0, colour SHALL be sampled in the oReq cycle and the output SHALL follow one cycle later.

Reset
REQ-015 On Reset at a Clock edge, regardless of Enable, the module SHALL:
- clear h_cnt, v_cnt and the delay line;
- set oVGA_R/G/B to 0 and oVGA_BLANK to 0;
- drive the syncs to their inactive levels.
REQ-016 Reset mid-frame SHALL abandon the frame; the first enabled cycle after release SHALL be h_cnt=0, v_cnt=0 with oFrame_start=1.

Configuration
REQ-017 With VGA_TEST_PATTERN_EN defined and iTest_mode=1, the sampled colour SHALL be replaced by 8 vertical bars, each H_ACT/8 wide, selected by the delayed oCoord_X.
- Bar order: white, yellow, cyan, green, magenta, red, blue, black.
- Channel values: all-ones or 0.
- iRed/iGreen/iBlue SHALL be ignored while the pattern is selected.
REQ-018 Without VGA_TEST_PATTERN_EN, iTest_mode SHALL be present but ignored and no pattern logic SHALL be synthesised.

Verification
REQ-019 The bench SHALL cover these scenarios (default parameters, Enable=1):
- Reset then run one frame -> oFrame_start every 420000 cycles; oVGA_H_SYNC low for 96 cycles per 800; oVGA_V_SYNC low for 2 lines per 525.
- Line 35 (first active line), h_cnt=144 -> oReq=1 with X=0, Y=0; h_cnt=783 -> X=639 with oLine_end=1; h_cnt=784 -> oReq=0.
- iRed=0xA5 held only in the 3rd cycle after the oReq at X=10 -> oVGA_R=0xA5 on the 4th cycle only; blank high; sync aligned.
- Enable toggling 1/0 -> identical output sequence in enabled cycles; all outputs frozen otherwise.
- Reset asserted at v_cnt=200 -> next cycle RGB=0, blank=0, syncs high; after release oFrame_start=1.
- VGA_TEST_PATTERN_EN defined, iTest_mode=1 -> X=0..79 gives white (0xFF,0xFF,0xFF); X=560..639 gives black; iRed is ignored.
